// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle restoring divider.
package div_pkg;
    localparam int DIV_W = 16;
    localparam int DIV_ITER = 16;
    localparam logic [DIV_W-1:0] DIV_ZERO_Q = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } div_state_t;

    // Two's complement negate when n is set; 16'h8000 maps to itself.
    function automatic logic [DIV_W-1:0] neg_if(input logic [DIV_W-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction
endpackage

// File: rtl/div_trial_sub.sv
// One restoring-division step: partial remainder minus zero-extended divisor.
module div_trial_sub
    import div_pkg::*;
(
    input  logic [DIV_W:0]   prem,
    input  logic [DIV_W-1:0] divisor,
    output logic [DIV_W:0]   diff,
    output logic             borrow
);
    assign {borrow, diff} = {1'b0, prem} - {2'b00, divisor};
endmodule

// File: rtl/sixteenbit_divider.sv
// Multi-cycle 16-bit restoring divider (DIV/DIVU): quotient for LO, remainder for HI.
module sixteenbit_divider
    import div_pkg::*;
#(
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [DIV_W-1:0] in_1,
    input  logic [DIV_W-1:0] in_2,
    output logic [DIV_W-1:0] quotient,
    output logic [DIV_W-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
    localparam int PW = DIV_W + 1;

    div_state_t       state_reg;
    logic [DIV_W:0]   prem_reg;
    logic [DIV_W-1:0] dividend_reg;
    logic [DIV_W-1:0] divisor_reg;
    logic [3:0]       count_reg;
    logic             q_neg_reg;
    logic             r_neg_reg;
    logic [DIV_W-1:0] quotient_reg;
    logic [DIV_W-1:0] remainder_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             dbz_reg;

    logic             signed_mode;
    logic [DIV_W-1:0] abs_1;
    logic [DIV_W-1:0] abs_2;
    logic [DIV_W:0]   shifted;
    logic [DIV_W:0]   trial;
    logic             borrow;

    assign signed_mode = SIGNED_EN && is_signed;
    assign abs_1 = neg_if(in_1, signed_mode && in_1[DIV_W-1]);
    assign abs_2 = neg_if(in_2, signed_mode && in_2[DIV_W-1]);

    // The restore keeps prem below the divisor, so its top bit drops out of the shift.
    assign shifted = PW'({prem_reg, dividend_reg[DIV_W-1]});

    div_trial_sub u_trial (
        .prem    (shifted),
        .divisor (divisor_reg),
        .diff    (trial),
        .borrow  (borrow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            prem_reg      <= '0;
            dividend_reg  <= '0;
            divisor_reg   <= '0;
            count_reg     <= '0;
            q_neg_reg     <= 1'b0;
            r_neg_reg     <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            dbz_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (in_2 == '0) begin
                            quotient_reg  <= DIV_ZERO_Q;
                            remainder_reg <= in_1;
                            dbz_reg       <= 1'b1;
                            done_reg      <= 1'b1;
                        end else begin
                            dividend_reg <= abs_1;
                            divisor_reg  <= abs_2;
                            q_neg_reg    <= signed_mode && (in_1[DIV_W-1] ^ in_2[DIV_W-1]);
                            r_neg_reg    <= signed_mode && in_1[DIV_W-1];
                            prem_reg     <= '0;
                            count_reg    <= 4'(DIV_ITER - 1);
                            dbz_reg      <= 1'b0;
                            busy_reg     <= 1'b1;
                            state_reg    <= RUN;
                        end
                    end
                end
                RUN: begin
                    prem_reg     <= borrow ? shifted : trial;
                    dividend_reg <= {dividend_reg[DIV_W-2:0], ~borrow};
                    if (count_reg == 4'd0) begin
                        state_reg <= FIX;
                    end else begin
                        count_reg <= count_reg - 4'd1;
                    end
                end
                FIX: begin
                    quotient_reg  <= neg_if(dividend_reg, q_neg_reg);
                    remainder_reg <= neg_if(prem_reg[DIV_W-1:0], r_neg_reg);
                    done_reg      <= 1'b1;
                    busy_reg      <= 1'b0;
                    state_reg     <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign div_by_zero = dbz_reg;
endmodule

// File: doc/sixteenbit_divider.md
# sixteenbit_divider

Multi-cycle 16-bit restoring divider for the MIPS datapath. It serves DIV/DIVU and produces a quotient for LO and a remainder for HI. It is the inverse companion of the 16-bit adder: each iteration performs one trial subtraction, so a full divide takes one cycle per quotient bit. The control unit stalls on `busy` and captures the results on `done`.

## Interface
- `SIGNED_EN`, default 1: when 0, `is_signed` is ignored and every divide is unsigned. This removes the sign-fixup logic.

- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a divide. Sampled only in IDLE.
- `is_signed` in 1: 1 = DIV (two's complement), 0 = DIVU.
- `in_1` in 16: dividend.
- `in_2` in 16: divisor.
- `quotient` out 16: result for LO. Registered.
- `remainder` out 16: result for HI. Registered.
- `busy` out 1: high while a divide is in progress.
- `done` out 1: one-cycle pulse when results become valid.
- `div_by_zero` out 1: set together with `done` when `in_2` was 0.

## Operation
- **States:** IDLE, RUN, FIX.
- **IDLE, `start`=1, `in_2`≠0:**
  - Latch operands.
  - In signed mode, take absolute values and record `q_neg` = sign(`in_1`) XOR sign(`in_2`), and `r_neg` = sign(`in_1`).
  - Clear the 17-bit partial remainder. Set `count` = 15. Go to RUN.
- **IDLE, `start`=1, `in_2`=0:**
  - Stay in IDLE.
  - Next cycle: `quotient`=16'hFFFF, `remainder`=`in_1`, `div_by_zero`=1, `done`=1.
- **RUN, each cycle:**
  - Shift `{prem, dividend}` left by 1.
  - Trial = prem − divisor, 17 bits.
  - If the trial is non-negative, prem = trial and the quotient bit = 1. Otherwise prem is kept and the bit = 0.
  - When `count`=0, go to FIX. Otherwise decrement `count`.
- **FIX:**
  - Negate the quotient if `q_neg`; negate the remainder if `r_neg`. Truncate both to 16 bits.
  - Register the outputs, pulse `done`, return to IDLE.
- **Sign rules:**
  - The remainder takes the sign of the dividend; the quotient truncates toward zero.
  - 16'h8000 / 16'hFFFF in signed mode gives quotient 16'h8000, remainder 0. No trap.
- **Result hold:** `quotient`, `remainder` and `div_by_zero` hold their values until the next accepted `start`. `div_by_zero` clears on an accepted `start`.
- **Busy window:** `start` while `busy` is ignored, and so are operand changes.
- **Reset:**
  - `rst` has priority over everything and takes effect on the next edge, including mid-RUN.
  - State goes to IDLE. All outputs go to 0: `quotient`=0, `remainder`=0, `busy`=0, `done`=0, `div_by_zero`=0.
  - An in-flight divide is abandoned and no `done` is produced for it.

## Timing
- `start` accepted at edge k:
  - `busy`=1 in the cycles following edges k through k+16 (17 cycles).
  - `done`=1 for exactly the cycle following edge k+17, with the results valid in that same cycle.
- Divide by zero: `done` and `div_by_zero` follow edge k directly (latency 1). `busy` stays 0.
- `done` and `busy` are never high in the same cycle.
- A new `start` may be asserted in the same cycle as `done`. It is accepted because the state is IDLE.
- All outputs come directly from registers. There are no combinational paths from inputs to outputs.

## Structure
- **Package `div_pkg`:**
  - State enum (IDLE, RUN, FIX).
  - `DIV_W` = 16.
  - `DIV_ITER` = 16.
  - `DIV_ZERO_Q` = 16'hFFFF.
- **Sub-module `div_trial_sub`:** combinational 17-bit subtract of the partial remainder minus the zero-extended divisor. Outputs the difference and a `borrow` flag.
- **Top level:** FSM, 4-bit iteration counter, operand/remainder/quotient shift registers, sign-fixup muxes.

## Test plan
- **Unsigned divide:** 16'hABCD / 16'h0011, `is_signed`=0 → `quotient`=16'h0A1B, `remainder`=16'h0002. `done` 17 cycles after the accepting edge; `busy` high for 17 cycles.
- **Signed, negative dividend:** 16'hFFF9 / 16'h0002 (−7/2), `is_signed`=1 → `quotient`=16'hFFFD, `remainder`=16'hFFFF.
- **Signed overflow case:** 16'h8000 / 16'hFFFF, `is_signed`=1 → `quotient`=16'h8000, `remainder`=16'h0000, `div_by_zero`=0.
- **Divide by zero:** 16'h1234 / 16'h0000 → next cycle `done`=1, `div_by_zero`=1, `quotient`=16'hFFFF, `remainder`=16'h1234. `busy` never rises.
- **Ignored start:** 16'hFFFF / 16'hFFFF unsigned, with a second `start` (operands 16'h0010 / 16'h0002) at cycle 5 of RUN → single `done`, `quotient`=16'h0001, `remainder`=0.
- **Reset mid-divide:** assert `rst` for one cycle at RUN cycle 8 → next cycle all outputs 0, state IDLE, no `done` afterwards. A following 16'h0064 / 16'h0007 gives `quotient`=16'h000E, `remainder`=16'h0002.
